// File: rtl/gcd_pkg.sv
// Shared types and defaults for the gcd engine and its dispatch front end.
package gcd_pkg;

   localparam int GCD_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } dispatch_state_t;

endpackage

// File: rtl/gcd_op_fifo.sv
// Operand-pair FIFO in front of the gcd engine; registered read side, no pass-through.
module gcd_op_fifo
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
)
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers are exactly log2(DEPTH) bits so they wrap without explicit compare.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/gcd_dispatch.sv
// Feeds queued operand pairs to the gcd engine one job at a time and holds
// each result with its WAIT-cycle latency until the consumer takes it.
//
// state | meaning
// IDLE  | no job in flight; leave when the FIFO holds a pair
// ISSUE | one cycle: start pulse, operands from FIFO head, pop
// WAIT  | counting cycles until the engine reports done
// HOLD  | result register valid, waiting for out_ready
module gcd_dispatch
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH,
   parameter int DEPTH = 4,
   parameter int CW    = 16
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             gcd_start,
   output logic [WIDTH-1:0] gcd_a,
   output logic [WIDTH-1:0] gcd_b,
   input  logic             gcd_done,
   input  logic [WIDTH-1:0] gcd_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [CW-1:0]    out_cycles
);

   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] CNT_MAX = '1;

   dispatch_state_t  state_q;
   dispatch_state_t  state_d;
   logic [PW-1:0]    head;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             push;
   logic             pop;
   logic             issue_ok;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_inc;

   assign in_ready = ~fifo_full;
   assign push     = in_valid & in_ready;
   assign pop      = (state_q == ISSUE);
   assign issue_ok = pop & ~fifo_empty;

   gcd_op_fifo #(
      .WIDTH (PW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata ({a_in, b_in}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign gcd_start = (state_q == ISSUE);
   assign gcd_a     = issue_ok ? head[PW-1:WIDTH] : '0;
   assign gcd_b     = issue_ok ? head[WIDTH-1:0]  : '0;

   // The done cycle itself is counted, so the captured value is cnt_q + 1.
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fifo_count != '0) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (gcd_done) state_d = HOLD;
         HOLD:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_cycles <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ISSUE: cnt_q <= '0;
            WAIT: begin
               cnt_q <= cnt_inc;
               if (gcd_done) begin
                  out_result <= gcd_result;
                  out_cycles <= cnt_inc;
                  out_valid  <= 1'b1;
               end
            end
            HOLD: if (out_ready) out_valid <= 1'b0;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule
